// File: rtl/program_counter.sv
// Instruction-fetch program counter for the RV32 core.
// Holds the address of the current instruction. On each enabled clock it
// advances either sequentially or to a branch/jump target. It also exports
// the combinational next-PC for fetch/prefetch and link-address logic.
module program_counter #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            branch_enable,
  input  logic            branch_is_relative,
  input  logic [XLEN-1:0] branch_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
);

  localparam logic [XLEN-1:0] INCR = XLEN'(INSTR_BYTES);

  // Address adder: modulo 2^XLEN, so the carry is dropped.
  // A negative offset in two's complement wraps naturally to a backward
  // target. Targets are not masked for alignment; the decode/exec stage
  // checks alignment.
  function automatic logic [XLEN-1:0] add_wrap(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    return a + b;
  endfunction

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next-PC select: a branch overrides the sequential step.
  // branch_is_relative has no effect unless a branch is requested.
  always_comb begin
    pc_d = add_wrap(pc_q, INCR);
    if (branch_enable) begin
      if (branch_is_relative) pc_d = add_wrap(pc_q, branch_addr);
      else                    pc_d = branch_addr;
    end
  end

  // PC register: reset is asynchronous and takes priority.
  // With en low, the register holds and any branch request that cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  pc_q <= RESET_VECTOR;
    else if (en) pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

endmodule

// File: tb/tb_program_counter.sv
// Directed testbench for program_counter: reset, sequential advance, absolute
// and relative branches, enable hold, asynchronous mid-cycle reset and wrap.
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        branch_enable;
  logic        branch_is_relative;
  logic [31:0] branch_addr;
  logic [31:0] pc;
  logic [31:0] pc_next;

  int n_checks = 0;
  int n_fail   = 0;

  program_counter #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .INSTR_BYTES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .branch_enable(branch_enable),
    .branch_is_relative(branch_is_relative),
    .branch_addr(branch_addr),
    .pc(pc),
    .pc_next(pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for the rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the falling edge, where the inputs are driven.
  task automatic drive_edge();
    @(negedge clk);
  endtask

  initial begin
    rst_n              = 1'b0;
    en                 = 1'b0;
    branch_enable      = 1'b0;
    branch_is_relative = 1'b0;
    branch_addr        = 32'h0;

    // Step 1: reset for two cycles, then release with en=0.
    #1;
    check("rst_async_pc", pc, 32'h0);
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_pc_next", pc_next, 32'h4);
    drive_edge();
    rst_n = 1'b1;
    tick();
    check("hold_after_release", pc, 32'h0);

    // Step 2: sequential advance.
    drive_edge();
    en = 1'b1;
    tick(); check("seq_1", pc, 32'h4); check("seq_1_next", pc_next, 32'h8);
    tick(); check("seq_2", pc, 32'h8); check("seq_2_next", pc_next, 32'hC);
    tick(); check("seq_3", pc, 32'hC); check("seq_3_next", pc_next, 32'h10);

    // Step 3: absolute branch for one cycle.
    drive_edge();
    branch_enable = 1'b1; branch_is_relative = 1'b0; branch_addr = 32'h1000;
    #1 check("abs_next", pc_next, 32'h1000);
    tick(); check("abs_taken", pc, 32'h1000);
    drive_edge();
    branch_enable = 1'b0;
    tick(); check("abs_seq_1", pc, 32'h1004);
    tick(); check("abs_seq_2", pc, 32'h1008);
    tick(); check("abs_seq_3", pc, 32'h100C);

    // Step 4: relative branches, forward and backward.
    drive_edge();
    branch_enable = 1'b1; branch_is_relative = 1'b1; branch_addr = 32'h100;
    #1 check("rel_next", pc_next, 32'h110C);
    tick(); check("rel_taken", pc, 32'h110C);
    drive_edge();
    branch_enable = 1'b0;
    tick(); check("rel_seq", pc, 32'h1110);
    drive_edge();
    branch_enable = 1'b1; branch_is_relative = 1'b0; branch_addr = 32'h2000;
    tick(); check("abs_2000", pc, 32'h2000);
    drive_edge();
    branch_is_relative = 1'b1; branch_addr = 32'hFFFF_FFF0;
    tick(); check("rel_negative", pc, 32'h1FF0);

    // Step 5: en=0 drops the branch requests; pc_next still tracks the inputs.
    drive_edge();
    en = 1'b0; branch_enable = 1'b1; branch_is_relative = 1'b0; branch_addr = 32'h2000;
    tick(); check("hold_1", pc, 32'h1FF0); check("hold_1_next", pc_next, 32'h2000);
    tick(); check("hold_2", pc, 32'h1FF0);
    tick(); check("hold_3", pc, 32'h1FF0); check("hold_3_next", pc_next, 32'h2000);
    drive_edge();
    branch_enable = 1'b0; branch_is_relative = 1'b1; branch_addr = 32'h55;
    #1 check("rel_ignored_next", pc_next, 32'h1FF4);
    drive_edge();
    en = 1'b1;
    tick(); check("resume", pc, 32'h1FF4);

    // Step 6: asynchronous reset in the middle of a cycle.
    #3 rst_n = 1'b0;
    #1 check("midcycle_rst_pc", pc, 32'h0);
    check("midcycle_rst_next", pc_next, 32'h4);
    drive_edge();
    branch_enable = 1'b1; branch_is_relative = 1'b0; branch_addr = 32'h40;
    tick(); check("rst_dominates_branch", pc, 32'h0);
    check("rst_branch_next", pc_next, 32'h40);
    drive_edge();
    branch_enable = 1'b0; rst_n = 1'b1;
    tick(); check("post_rst_1", pc, 32'h4);
    tick(); check("post_rst_2", pc, 32'h8);

    // Wrap: 0xFFFFFFFC + 4 = 0.
    drive_edge();
    branch_enable = 1'b1; branch_is_relative = 1'b0; branch_addr = 32'hFFFF_FFFC;
    tick(); check("wrap_setup", pc, 32'hFFFF_FFFC);
    drive_edge();
    branch_enable = 1'b0;
    #1 check("wrap_next", pc_next, 32'h0);
    tick(); check("wrap_pc", pc, 32'h0);

    // Backward relative branch from 0 wraps downward; a misaligned target passes through unmodified.
    drive_edge();
    branch_enable = 1'b1; branch_is_relative = 1'b1; branch_addr = 32'hFFFF_FFF8;
    tick(); check("wrap_down", pc, 32'hFFFF_FFF8);
    drive_edge();
    branch_is_relative = 1'b0; branch_addr = 32'h0000_1003;
    tick(); check("unaligned_target", pc, 32'h1003);
    drive_edge();
    branch_enable = 1'b0;
    tick(); check("unaligned_seq", pc, 32'h1007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
